// File: rtl/bbox_tracker_multi.sv
// rtl/bbox_tracker_multi.sv - multi-channel colour bounding-box tracker with CPU message FIFO
// Optional feature macro: BBOX_PIXCOUNT_EN (per-channel accepted-pixel counts, EMIT_C records, MIN_PIX)
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   in_valid/in_sop/in_eop    pixel stream beat qualifiers; in_video sampled on the sop beat
//   det                       raw per-channel detect flags for the current beat
//   box_flat, box_vld         latched per-channel {left,right,top,bottom} boxes and valid flags
//   s_chipselect..s_readdata  Avalon-MM register slave, registered read data
module bbox_tracker_multi #(
  parameter int NUM_COL      = 6,
  parameter int IMAGE_W      = 640,
  parameter int IMAGE_H      = 480,
  parameter int FILT_LEN     = 3,
  parameter int MSG_INTERVAL = 6,
  parameter int FIFO_DEPTH   = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_video,
  input  logic [NUM_COL-1:0]    det,
  output logic [NUM_COL*44-1:0] box_flat,
  output logic [NUM_COL-1:0]    box_vld,
  input  logic                  s_chipselect,
  input  logic                  s_read,
  input  logic                  s_write,
  input  logic [2:0]            s_address,
  input  logic [31:0]           s_writedata,
  output logic [31:0]           s_readdata
);

  localparam int HL  = (FILT_LEN > 1) ? FILT_LEN - 1 : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int FCW = (MSG_INTERVAL > 1) ? $clog2(MSG_INTERVAL) : 1;
`ifdef BBOX_PIXCOUNT_EN
  localparam int WPC = 3;
`else
  localparam int WPC = 2;
`endif
  localparam int BURST = WPC * NUM_COL;

  typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B, EMIT_C} state_e;

  logic [10:0]                x_q, x_d, y_q, y_d;
  logic                       video_q, video_d;
  logic [NUM_COL-1:0][HL-1:0] hist_q, hist_d;
  logic [NUM_COL-1:0][10:0]   xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [NUM_COL*44-1:0]      box_q, box_d;
  logic [NUM_COL-1:0]         vld_q, vld_d, acc, mask_q;
  logic [FCW-1:0]             fcnt_q, fcnt_d;
  state_e                     state_q, state_d;
  logic [3:0]                 ch_q, ch_d;
  logic [31:0]                mem [FIFO_DEPTH];
  logic [AW-1:0]              wp_q, rp_q;
  logic [AW:0]                used_q;
  logic                       rd_q;
  logic [31:0]                rdata_q, rdata_d, used32, wr_data;
  logic [7:0]                 used_sat;
  logic [43:0]                sel_box;
  logic                       sop_b, pix, eop_v, wr_cmd, flush, rd_fire, pop, wr_en, fits;
  logic                       unused_wdata;
`ifdef BBOX_PIXCOUNT_EN
  logic [NUM_COL-1:0][19:0]   pcnt_q, pcnt_d, plat_q;
  logic [19:0]                min_pix_q, sel_cnt;
`endif

  assign unused_wdata = ^s_writedata;

  assign sop_b   = in_valid & in_sop;
  assign pix     = in_valid & ~in_sop & video_q;
  // A single-beat packet carries its video flag on the same beat as its eop.
  assign eop_v   = in_valid & in_eop & (in_sop ? in_video : video_q);
  assign wr_cmd  = s_chipselect & s_write;
  assign flush   = wr_cmd & (s_address == 3'd0) & s_writedata[4];
  assign rd_fire = s_chipselect & s_read & ~rd_q;
  assign pop     = rd_fire & (s_address == 3'd1) & (used_q != '0) & ~flush;
  assign used32  = 32'(used_q);
  assign used_sat = (used32 > 32'd255) ? 8'hFF : used32[7:0];
  assign fits    = (used32 + 32'(BURST)) <= 32'(FIFO_DEPTH);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    video_d = video_q;
    if (sop_b) begin
      x_d = '0;
      y_d = '0;
      video_d = in_video;
    end else if (in_valid) begin
      if (x_q == 11'(IMAGE_W - 1)) begin
        x_d = '0;
        y_d = y_q + 11'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  // History is treated as empty at x==0 so runs never span a line boundary.
  always_comb begin
    logic [HL:0] sh;
    sh = '0;
    hist_d = hist_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    for (int c = 0; c < NUM_COL; c++) begin
      sh = {hist_q[c] & {HL{x_q != 11'd0}}, det[c]};
      acc[c] = pix & det[c] & mask_q[c] & ((FILT_LEN == 1) || ((x_q != 11'd0) && (&hist_q[c])));
      if (pix) hist_d[c] = sh[HL-1:0];
      if (sop_b) begin
        xmin_d[c] = 11'(IMAGE_W - 1);
        xmax_d[c] = '0;
        ymin_d[c] = 11'(IMAGE_H - 1);
        ymax_d[c] = '0;
      end else if (acc[c]) begin
        if (x_q < xmin_q[c]) xmin_d[c] = x_q;
        if (x_q > xmax_q[c]) xmax_d[c] = x_q;
        if (y_q < ymin_q[c]) ymin_d[c] = y_q;
        if (y_q > ymax_q[c]) ymax_d[c] = y_q;
      end
    end
  end

`ifdef BBOX_PIXCOUNT_EN
  always_comb begin
    pcnt_d = pcnt_q;
    for (int c = 0; c < NUM_COL; c++) begin
      if (sop_b) pcnt_d[c] = '0;
      else if (acc[c] && (pcnt_q[c] != 20'hFFFFF)) pcnt_d[c] = pcnt_q[c] + 20'd1;
    end
  end
`endif

  // Latch from next-state values so the eop beat's own pixel is included.
  always_comb begin
    box_d = box_q;
    vld_d = vld_q;
    if (eop_v) begin
      for (int c = 0; c < NUM_COL; c++) begin
        box_d[c*44 +: 44] = {xmin_d[c], xmax_d[c], ymin_d[c], ymax_d[c]};
        vld_d[c] = (xmax_d[c] >= xmin_d[c]);
`ifdef BBOX_PIXCOUNT_EN
        vld_d[c] = vld_d[c] & (pcnt_d[c] >= min_pix_q);
`endif
      end
    end
  end

  always_comb begin
    sel_box = '0;
    for (int c = 0; c < NUM_COL; c++)
      if (ch_q == 4'(c)) sel_box = box_q[c*44 +: 44];
  end

`ifdef BBOX_PIXCOUNT_EN
  always_comb begin
    sel_cnt = '0;
    for (int c = 0; c < NUM_COL; c++)
      if (ch_q == 4'(c)) sel_cnt = plat_q[c];
  end
`endif

  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    fcnt_d = fcnt_q;
    wr_en = 1'b0;
    wr_data = '0;
    case (state_q)
      IDLE: begin
        if (eop_v) begin
          if ((fcnt_q == '0) && fits) begin
            state_d = EMIT_A;
            ch_d = '0;
            fcnt_d = FCW'(MSG_INTERVAL - 1);
          end else if (fcnt_q != '0) begin
            fcnt_d = fcnt_q - FCW'(1);
          end
        end
      end
      EMIT_A: begin
        wr_en = 1'b1;
        wr_data = {2'b01, ch_q, 4'b0, sel_box[43:22]};
        state_d = EMIT_B;
      end
      EMIT_B: begin
        wr_en = 1'b1;
        wr_data = {2'b10, ch_q, 4'b0, sel_box[21:0]};
`ifdef BBOX_PIXCOUNT_EN
        state_d = EMIT_C;
`else
        if (ch_q == 4'(NUM_COL - 1)) begin
          state_d = IDLE;
        end else begin
          ch_d = ch_q + 4'd1;
          state_d = EMIT_A;
        end
`endif
      end
`ifdef BBOX_PIXCOUNT_EN
      EMIT_C: begin
        wr_en = 1'b1;
        wr_data = {2'b11, ch_q, 6'b0, sel_cnt};
        if (ch_q == 4'(NUM_COL - 1)) begin
          state_d = IDLE;
        end else begin
          ch_d = ch_q + 4'd1;
          state_d = EMIT_A;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      wr_en = 1'b0;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (s_address)
      3'd0: rdata_d = {16'b0, used_sat, 7'b0, state_q != IDLE};
      3'd1: if (used_q != '0) rdata_d = mem[rp_q];
      3'd2: rdata_d = 32'h1234EEE3;
      3'd3: rdata_d[NUM_COL-1:0] = mask_q;
`ifdef BBOX_PIXCOUNT_EN
      3'd4: rdata_d[19:0] = min_pix_q;
`endif
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
      video_q <= 1'b0;
      hist_q <= '0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      box_q <= '0;
      vld_q <= '0;
      mask_q <= '1;
      fcnt_q <= '0;
      state_q <= IDLE;
      ch_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      used_q <= '0;
      rd_q <= 1'b0;
      rdata_q <= '0;
`ifdef BBOX_PIXCOUNT_EN
      pcnt_q <= '0;
      plat_q <= '0;
      min_pix_q <= '0;
`endif
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      video_q <= video_d;
      hist_q <= hist_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      box_q <= box_d;
      vld_q <= vld_d;
      fcnt_q <= fcnt_d;
      state_q <= state_d;
      ch_q <= ch_d;
      rd_q <= s_read;
      if (rd_fire) rdata_q <= rdata_d;
      if (wr_cmd && (s_address == 3'd3)) mask_q <= s_writedata[NUM_COL-1:0];
`ifdef BBOX_PIXCOUNT_EN
      pcnt_q <= pcnt_d;
      if (eop_v) plat_q <= pcnt_d;
      if (wr_cmd && (s_address == 3'd4)) min_pix_q <= s_writedata[19:0];
`endif
      if (flush) begin
        wp_q <= '0;
        rp_q <= '0;
        used_q <= '0;
      end else begin
        if (wr_en) wp_q <= wp_q + AW'(1);
        if (pop) rp_q <= rp_q + AW'(1);
        used_q <= used_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp_q] <= wr_data;
  end

  assign box_flat   = box_q;
  assign box_vld    = vld_q;
  assign s_readdata = rdata_q;

endmodule

// File: tb/tb_bbox_tracker_multi.sv
// tb/tb_bbox_tracker_multi.sv - scoreboard bench for bbox_tracker_multi
module tb_bbox_tracker_multi;
  localparam int NUM_COL = 2, IMAGE_W = 128, IMAGE_H = 64, FILT_LEN = 3;
  localparam int MSG_INTERVAL = 2, FIFO_DEPTH = 16;
`ifdef BBOX_PIXCOUNT_EN
  localparam int WPC = 3;
`else
  localparam int WPC = 2;
`endif
  localparam int BURST = WPC * NUM_COL;

  logic clk, reset_n, in_valid, in_sop, in_eop, in_video;
  logic [NUM_COL-1:0] det, box_vld;
  logic [NUM_COL*44-1:0] box_flat;
  logic s_chipselect, s_read, s_write;
  logic [2:0] s_address;
  logic [31:0] s_writedata, s_readdata, d;

  bbox_tracker_multi #(
    .NUM_COL(NUM_COL), .IMAGE_W(IMAGE_W), .IMAGE_H(IMAGE_H), .FILT_LEN(FILT_LEN),
    .MSG_INTERVAL(MSG_INTERVAL), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_video(in_video), .det(det), .box_flat(box_flat), .box_vld(box_vld),
    .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_writedata(s_writedata), .s_readdata(s_readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  int n_tests, n_fail;
  logic [31:0] sb[$];
  int m_used, m_fcnt, m_minpix;
  logic [NUM_COL-1:0] m_mask, evld;
  int rx0[NUM_COL], rx1[NUM_COL], ry0[NUM_COL], ry1[NUM_COL];
  int exmin[NUM_COL], exmax[NUM_COL], eymin[NUM_COL], eymax[NUM_COL];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mm_write(input logic [2:0] a, input logic [31:0] v);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = v;
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_write = 1'b0; s_writedata = '0;
  endtask

  task automatic mm_read(input logic [2:0] a, output logic [31:0] q);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    @(posedge clk); #1;
    q = s_readdata;
    s_chipselect = 1'b0; s_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read_msg();
    logic [31:0] q;
    mm_read(3'd1, q);
    if (sb.size() == 0) begin
      check("msg_empty", q, 0);
    end else begin
      check("msg", q, sb.pop_front());
      m_used--;
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) read_msg();
  endtask

  task automatic check_status(input string tag);
    logic [31:0] q;
    logic [7:0] u;
    u = (m_used > 255) ? 8'hFF : 8'(m_used);
    mm_read(3'd0, q);
    check(tag, q, {16'b0, u, 8'b0});
  endtask

  task automatic set_rect(input int c, input int x0, input int x1, input int y0, input int y1);
    rx0[c] = x0; rx1[c] = x1; ry0[c] = y0; ry1[c] = y1;
  endtask

  task automatic check_box(input string tag);
    for (int c = 0; c < NUM_COL; c++)
      check($sformatf("%s_box%0d", tag, c), box_flat[c*44 +: 44],
            {11'(exmin[c]), 11'(exmax[c]), 11'(eymin[c]), 11'(eymax[c])});
    check({tag, "_vld"}, box_vld, evld);
  endtask

  // Drives one packet; the bench model counts detect runs per line to decide acceptance.
  task automatic send_frame(input int nlines, input bit video, input bit do_flush);
    int run[NUM_COL], mxmin[NUM_COL], mxmax[NUM_COL], mymin[NUM_COL], mymax[NUM_COL], cnt[NUM_COL];
    logic [NUM_COL-1:0] dv;
    bit dc;
    for (int c = 0; c < NUM_COL; c++) begin
      run[c] = 0; cnt[c] = 0;
      mxmin[c] = IMAGE_W - 1; mxmax[c] = 0; mymin[c] = IMAGE_H - 1; mymax[c] = 0;
    end
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_video = video; det = '0;
    @(posedge clk); #1;
    in_sop = 1'b0; in_video = 1'b0;
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < IMAGE_W; x++) begin
        for (int c = 0; c < NUM_COL; c++) begin
          dc = (x >= rx0[c]) && (x <= rx1[c]) && (y >= ry0[c]) && (y <= ry1[c]);
          dv[c] = dc;
          if (x == 0) run[c] = 0;
          run[c] = dc ? run[c] + 1 : 0;
          if (video && dc && (run[c] >= FILT_LEN) && m_mask[c]) begin
            cnt[c]++;
            if (x < mxmin[c]) mxmin[c] = x;
            if (x > mxmax[c]) mxmax[c] = x;
            if (y < mymin[c]) mymin[c] = y;
            if (y > mymax[c]) mymax[c] = y;
          end
        end
        det = dv;
        in_eop = (y == nlines - 1) && (x == IMAGE_W - 1);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; in_eop = 1'b0; det = '0;
    if (video) begin
      for (int c = 0; c < NUM_COL; c++) begin
        exmin[c] = mxmin[c]; exmax[c] = mxmax[c]; eymin[c] = mymin[c]; eymax[c] = mymax[c];
        evld[c] = (mxmax[c] >= mxmin[c]) && (cnt[c] >= m_minpix);
      end
      if ((m_fcnt == 0) && (m_used + BURST <= FIFO_DEPTH)) begin
        for (int c = 0; c < NUM_COL; c++) begin
          sb.push_back({2'b01, 4'(c), 4'b0, 11'(mxmin[c]), 11'(mxmax[c])});
          sb.push_back({2'b10, 4'(c), 4'b0, 11'(mymin[c]), 11'(mymax[c])});
`ifdef BBOX_PIXCOUNT_EN
          sb.push_back({2'b11, 4'(c), 6'b0, 20'(cnt[c])});
`endif
        end
        m_used += BURST;
        m_fcnt = MSG_INTERVAL - 1;
      end else if (m_fcnt > 0) begin
        m_fcnt--;
      end
    end
    if (do_flush) begin
      @(posedge clk); #1;
      mm_write(3'd0, 32'h10);
      sb.delete();
      m_used = 0;
      check_status("status_flush_next");
    end
    repeat (BURST + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; in_valid = 0; in_sop = 0; in_eop = 0; in_video = 0; det = '0;
    s_chipselect = 0; s_read = 0; s_write = 0; s_address = '0; s_writedata = '0;
    m_used = 0; m_fcnt = 0; m_minpix = 0; m_mask = '1; evld = '0;
    for (int c = 0; c < NUM_COL; c++) set_rect(c, 1, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    check("rst_vld", box_vld, 0);
    check("rst_box", box_flat, 0);
    check("rst_rdata", s_readdata, 0);
    mm_read(3'd2, d); check("id", d, 32'h1234EEE3);
    mm_read(3'd3, d); check("enable_rst", d, 32'h3);
    mm_read(3'd4, d); check("minpix_rst", d, 0);
    check_status("status_rst");

    // Blob on ch0 and isolated single-pixel pulses on ch1.
    set_rect(0, 100, 109, 50, 59);
    set_rect(1, 20, 20, 5, 10);
    send_frame(60, 1'b1, 1'b0);
    check_box("blob");

    set_rect(0, 1, 0, 1, 0);
    set_rect(1, 1, 0, 1, 0);
    repeat (3) send_frame(1, 1'b1, 1'b0);
    check_status("status_two_bursts");
    send_frame(1, 1'b0, 1'b0);
    check_box("nonvideo_ignored");
    check_status("status_nonvideo");
    drain();
    read_msg();

    // Fill until a burst no longer fits, then hit a counter-zero eop.
    guard = 0;
    while ((m_used + BURST <= FIFO_DEPTH) && (guard < 40)) begin
      send_frame(1, 1'b1, 1'b0);
      guard++;
    end
    if (m_fcnt != 0) send_frame(1, 1'b1, 1'b0);
    while (m_used > FIFO_DEPTH - 3) read_msg();
    check_status("status_near_full");
    send_frame(1, 1'b1, 1'b0);
    check_status("status_no_burst");
    drain();
    send_frame(1, 1'b1, 1'b0);
    check_status("status_burst_after_drain");

    // Flush mid-burst.
    drain();
    send_frame(1, 1'b1, 1'b0);
    send_frame(1, 1'b1, 1'b1);
    check_status("status_flush_settled");
    read_msg();

    // Asynchronous reset in the middle of a frame.
    set_rect(0, 100, 109, 50, 59);
    send_frame(1, 1'b1, 1'b0);
    send_frame(60, 1'b1, 1'b0);
    check_box("blob2");
    mm_read(3'd2, d);
    in_valid = 1'b1; in_sop = 1'b1; in_video = 1'b1;
    @(posedge clk); #1;
    in_sop = 1'b0;
    repeat (20) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_vld", box_vld, 0);
    check("arst_box", box_flat, 0);
    check("arst_rdata", s_readdata, 0);
    in_valid = 1'b0; in_video = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb.delete(); m_used = 0; m_fcnt = 0; m_mask = '1; m_minpix = 0; evld = '0;
    check_status("status_after_reset");

    // Enable mask blocks ch0.
    mm_write(3'd3, 32'h2);
    mm_read(3'd3, d); check("enable_rb", d, 32'h2);
    m_mask = 2'b10;
    set_rect(0, 10, 20, 2, 4);
    set_rect(1, 30, 39, 2, 4);
    send_frame(6, 1'b1, 1'b0);
    check_box("masked");
    drain();

`ifdef BBOX_PIXCOUNT_EN
    mm_write(3'd3, 32'h3);
    m_mask = '1;
    mm_write(3'd4, 32'd50);
    mm_read(3'd4, d); check("minpix_rb", d, 32'd50);
    m_minpix = 50;
    set_rect(0, 10, 18, 1, 7);
    set_rect(1, 10, 19, 1, 7);
    send_frame(8, 1'b1, 1'b0);
    check_box("minpix");
    send_frame(8, 1'b1, 1'b0);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
